// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes a preset over pll_reconfig's
// Avalon-MM port, starts reconfig, waits for re-lock. Option: PLL_RECFG_LOCK_TIMEOUT_EN.
module pll_reconfig_seq #(
   parameter int SETTLE_CYC   = 16,
   parameter int LOCK_TIMEOUT = 1048575
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_req,
   input  logic        cfg_sel,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        active_sel
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int CW = (SW > TW) ? SW : TW;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

   // counter words: [22:18] idx, [17] odd, [16] bypass, [15:8] hi, [7:0] lo
   localparam logic [31:0] N_WORD  = 32'h0002_0302;
   localparam logic [31:0] M_WORD  = 32'h0000_1818;
   localparam logic [31:0] C0_WORD = 32'h0002_0302;
   localparam logic [31:0] C1_S0   = 32'h0006_0807;
   localparam logic [31:0] C1_S1   = 32'h0004_0A0A;

   typedef enum logic [3:0] {
      IDLE, W_MODE, W_N, W_M, W_C0, W_C1, W_START, SETTLE, WAIT_LOCK
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          act_q, act_d;
   logic          sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lk_meta_q, lk_sync_q;

   logic [5:0]    w_addr;
   logic [31:0]   w_data;
   state_t        w_next;

`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
   localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
   logic          err_q, err_d;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   assign mgmt_address   = addr_q;
   assign mgmt_writedata = data_q;
   assign mgmt_write     = wr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign active_sel     = act_q;

   // address, data and successor of the current write state
   always_comb begin
      w_addr = 6'd0;
      w_data = 32'd0;
      w_next = IDLE;
      unique case (state_q)
         W_MODE:  begin w_addr = 6'd0; w_data = 32'd0;   w_next = W_N;     end
         W_N:     begin w_addr = 6'd3; w_data = N_WORD;  w_next = W_M;     end
         W_M:     begin w_addr = 6'd4; w_data = M_WORD;  w_next = W_C0;    end
         W_C0:    begin w_addr = 6'd5; w_data = C0_WORD; w_next = W_C1;    end
         W_C1:    begin
            w_addr = 6'd5;
            w_data = sel_q ? C1_S1 : C1_S0;
            w_next = W_START;
         end
         W_START: begin w_addr = 6'd2; w_data = 32'd0;   w_next = SETTLE;  end
         default: ;
      endcase
   end

   // next-state and registered-output logic of the sequencer
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = wr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      act_d   = act_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cfg_req) begin
               sel_d   = cfg_sel;
               busy_d  = 1'b1;
               state_d = W_MODE;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         W_MODE, W_N, W_M, W_C0, W_C1, W_START: begin
            // raise write after a low cycle; drop it on acceptance
            if (!wr_q) begin
               wr_d   = 1'b1;
               addr_d = w_addr;
               data_d = w_data;
            end else if (!mgmt_waitrequest) begin
               wr_d    = 1'b0;
               state_d = w_next;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_LOCK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_LOCK: begin
            if (lk_sync_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               act_d   = sel_q;
               state_d = IDLE;
            end
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // state, outputs and lock synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= 6'd0;
         data_q    <= 32'd0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         act_q     <= 1'b0;
         sel_q     <= 1'b0;
         cnt_q     <= '0;
         lk_meta_q <= 1'b0;
         lk_sync_q <= 1'b0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         act_q     <= act_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         lk_meta_q <= pll_locked;
         lk_sync_q <= lk_meta_q;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
         err_q     <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected Avalon writes and
// done events are queued at request time and checked by a monitor.
module tb_pll_reconfig_seq;

   localparam int S  = 6;
   localparam int LT = 100;

   logic        clk;
   logic        rst_n;
   logic        cfg_req;
   logic        cfg_sel;
   logic        pll_locked;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest;
   logic        busy;
   logic        done;
   logic        error;
   logic        active_sel;

   pll_reconfig_seq #(.SETTLE_CYC(S), .LOCK_TIMEOUT(LT)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
      .pll_locked(pll_locked), .mgmt_address(mgmt_address),
      .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
      .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .done(done),
      .error(error), .active_sel(active_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int wr_total = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int m_stall = 0;
   int wr_pct = 0;
   bit hold_m = 0;

   logic [37:0] exp_q[$];
   bit          done_exp[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // counter word from divider fields
   function automatic logic [31:0] cword(input int hi, input int lo,
                                         input bit odd, input int idx);
      return (32'(idx) << 18) | (32'(odd) << 17) | (32'(hi) << 8) | 32'(lo);
   endfunction

   task automatic push_seq(input bit sel);
      exp_q.push_back({6'd0, 32'd0});
      exp_q.push_back({6'd3, cword(3, 2, 1, 0)});
      exp_q.push_back({6'd4, cword(24, 24, 0, 0)});
      exp_q.push_back({6'd5, cword(3, 2, 1, 0)});
      if (sel) exp_q.push_back({6'd5, cword(10, 10, 0, 1)});
      else     exp_q.push_back({6'd5, cword(8, 7, 1, 1)});
      exp_q.push_back({6'd2, 32'd0});
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Avalon slave: random or forced waitrequest
   initial begin
      int hold;
      hold = 0;
      mgmt_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            mgmt_waitrequest = 1'b0;
            hold = 0;
         end else if (hold > 0) begin
            mgmt_waitrequest = 1'b1;
            hold--;
         end else if (hold_m && mgmt_write && mgmt_address == 6'd4) begin
            mgmt_waitrequest = 1'b1;
            hold = 4;
            hold_m = 0;
         end else begin
            mgmt_waitrequest = ($urandom_range(0, 99) < wr_pct);
         end
      end
   end

   // monitor: bus transfers and done pulses
   initial begin
      logic [37:0] e;
      logic [5:0]  p_addr;
      logic [31:0] p_data;
      bit          p_stall, p_acc, p_done;
      int          stall;
      p_stall = 0; p_acc = 0; p_done = 0; stall = 0;
      p_addr = '0; p_data = '0;
      forever begin
         @(negedge clk);
         if (p_acc) chk("write_gap", mgmt_write, 0);
         p_acc = 0;
         if (mgmt_write) begin
            if (p_stall) begin
               chk("hold_addr", mgmt_address, p_addr);
               chk("hold_data", mgmt_writedata, p_data);
            end
            if (mgmt_waitrequest) begin
               p_stall = 1;
               p_addr = mgmt_address;
               p_data = mgmt_writedata;
               stall++;
            end else begin
               p_stall = 0;
               p_acc = 1;
               wr_total++;
               if (mgmt_address == 6'd4) m_stall = stall;
               stall = 0;
               if (mgmt_address == 6'd2) begin
                  start_cyc = cyc + 1;
                  start_cnt++;
               end
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_write: got a=%0d d=%0h expected none",
                           mgmt_address, mgmt_writedata);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", mgmt_address, e[37:32]);
                  chk("wr_data", mgmt_writedata, e[31:0]);
               end
            end
         end else begin
            p_stall = 0;
            stall = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_1cyc", p_done, 0);
            if (done_exp.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_done: got done expected none");
            end else begin
               chk("active_sel", active_sel, done_exp.pop_front());
               chk("busy_at_done", busy, 0);
               chk("error_at_done", error, 0);
            end
         end
         p_done = done;
      end
   end

   task automatic issue(input bit sel, input bit want_done);
      @(posedge clk);
      #2;
      cfg_req = 1'b1;
      cfg_sel = sel;
      push_seq(sel);
      if (want_done) done_exp.push_back(sel);
      @(posedge clk);
      #2;
      cfg_req = 1'b0;
      cfg_sel = 1'($urandom);
      @(negedge clk);
      chk("busy_set", busy, 1);
   endtask

   task automatic wait_done(input int d0);
      int i;
      for (i = 0; i < 3000 && done_cnt <= d0; i++) @(negedge clk);
      if (done_cnt <= d0) begin
         n_chk++;
         $display("FAIL done_timeout: got no done expected done");
      end
   endtask

   task automatic run(input bit sel, input bit lock_mode);
      int d0, s0, i;
      d0 = done_cnt;
      s0 = start_cnt;
      if (lock_mode) pll_locked = 1'b0;
      issue(sel, 1);
      if (lock_mode) begin
         for (i = 0; i < 3000 && start_cnt <= s0; i++) @(negedge clk);
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #2;
         pll_locked = 1'b1;
      end
      wait_done(d0);
      if (!lock_mode) chk("settle_latency", done_cyc - start_cyc, S + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1);
   end

   initial begin
      int w0, d0, i;
      rst_n = 1'b0;
      cfg_req = 1'b0;
      cfg_sel = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_addr", mgmt_address, 0);
      chk("rst_data", mgmt_writedata, 0);
      chk("rst_write", mgmt_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_active", active_sel, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      run(0, 0);
      run(1, 0);
      chk("active_sel_1", active_sel, 1);

      hold_m = 1;
      run(0, 0);
      chk("m_stall_cycles", m_stall, 5);

      d0 = done_cnt;
      w0 = wr_total;
      issue(0, 1);
      for (i = 0; i < 500 && wr_total < w0 + 2; i++) @(negedge clk);
      @(posedge clk);
      #2;
      cfg_req = 1'b1;
      cfg_sel = 1'b1;
      @(posedge clk);
      #2;
      cfg_req = 1'b0;
      wait_done(d0);
      chk("ignored_req_q", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      chk("ignored_req_busy", busy, 0);

      wr_pct = 30;
      for (int k = 0; k < 8; k++)
         run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wr_pct = 0;

      issue(1, 1);
      for (i = 0; i < 500; i++) begin
         @(negedge clk);
         if (mgmt_write && mgmt_address == 6'd5 &&
             mgmt_writedata[22:18] == 5'd0) break;
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_write", mgmt_write, 0);
      chk("arst_busy", busy, 0);
      exp_q.delete();
      done_exp.delete();
      w0 = wr_total;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("arst_no_writes", wr_total, w0);
      chk("arst_idle_busy", busy, 0);
      chk("arst_active", active_sel, 0);

`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
      d0 = done_cnt;
      pll_locked = 1'b0;
      issue(1, 0);
      for (i = 0; i < 3000 && busy; i++) @(negedge clk);
      chk("tmo_latency", cyc - start_cyc, S + LT);
      chk("tmo_error", error, 1);
      chk("tmo_no_done", done_cnt, d0);
      chk("tmo_active", active_sel, 0);
      pll_locked = 1'b1;
      d0 = done_cnt;
      issue(1, 1);
      chk("tmo_err_clear", error, 0);
      wait_done(d0);
`endif

      run(1, 0);
      chk("final_active", active_sel, 1);
      chk("final_q_empty", exp_q.size() + done_exp.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
